// File: rtl/rr_chan_mux_pkg.sv
// Shared types and helpers for the round-robin channel mux and its arbiter.
package rr_chan_mux_pkg;

  localparam int DEF_N_CH   = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Explicit wrap keeps the pointer in range when n is not a power of two.
  function automatic int next_ptr(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority encoder: first set req bit at or after ptr,
// wrapping from N_CH-1 back to 0.
module rr_arbiter
  import rr_chan_mux_pkg::*;
#(
  parameter  int N_CH = DEF_N_CH,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant_idx,
  output logic            any
);

  logic [2*N_CH-1:0] rot;

  // Rotated view: rot[k] is the request of channel (ptr + k) mod N_CH.
  assign rot = {req, req} >> ptr;

  always_comb begin
    int idx;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = int'(ptr) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        grant_idx = CH_W'(idx);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_chan_mux.sv
// N-channel to 1 valid/ready mux with round-robin arbitration and a registered
// output word. Define RR_CHAN_MUX_PRIO0_EN to give channel 0 strict priority.
//
// state | meaning
// EMPTY | output register holds no word, out_valid low
// FULL  | output register holds a word, out_valid high
module rr_chan_mux
  import rr_chan_mux_pkg::*;
#(
  parameter  int N_CH   = DEF_N_CH,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   arb_g, g;
  logic              arb_any, any;
  logic              accept, in_fire, out_fire, ptr_upd;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .grant_idx (arb_g),
    .any       (arb_any)
  );

`ifdef RR_CHAN_MUX_PRIO0_EN
  // Channel 0 overrides rotation and leaves the pointer where it was.
  assign g       = in_valid[0] ? '0 : arb_g;
  assign any     = in_valid[0] | arb_any;
  assign ptr_upd = in_fire & ~in_valid[0];
`else
  assign g       = arb_g;
  assign any     = arb_any;
  assign ptr_upd = in_fire;
`endif

  assign out_valid = (state_q == FULL);
  assign accept    = ~out_valid | out_ready;
  assign in_fire   = accept & any & ~rst;
  assign out_fire  = out_valid & out_ready;
  assign in_ready  = in_fire ? (N_CH'(1) << g) : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (g == CH_W'(i)) sel_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (in_fire) state_d = FULL;
      FULL:    if (out_fire && !in_fire) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_ch   <= '0;
      rr_ptr   <= '0;
    end else if (in_fire) begin
      out_data <= sel_data;
      out_ch   <= g;
      if (ptr_upd) rr_ptr <= CH_W'(next_ptr(int'(g), N_CH));
    end
  end

endmodule
